// File: rtl/axi_slice_pkg.sv
// Shared AXI4 payload types and constants for the register slice.
// Widths here define the packed layouts used on every channel.
package axi_slice_pkg;

    localparam int unsigned AXI_ID_WD    = 3;
    localparam int unsigned AXI_ADDR_WD  = 32;
    localparam int unsigned AXI_DATA_WD  = 64;
    localparam int unsigned AXI_STRB_WD  = AXI_DATA_WD / 8;
    localparam int unsigned AXI_LEN_WD   = 8;
    localparam int unsigned AXI_SIZE_WD  = 3;
    localparam int unsigned AXI_BURST_WD = 2;
    localparam int unsigned AXI_RESP_WD  = 2;

    localparam logic [AXI_RESP_WD-1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_ID_WD-1:0]    id;
        logic [AXI_ADDR_WD-1:0]  addr;
        logic [AXI_LEN_WD-1:0]   len;
        logic [AXI_SIZE_WD-1:0]  size;
        logic [AXI_BURST_WD-1:0] burst;
    } aw_t;

    typedef struct packed {
        logic [AXI_DATA_WD-1:0] data;
        logic [AXI_STRB_WD-1:0] strb;
        logic                   last;
    } w_t;

    typedef struct packed {
        logic [AXI_ID_WD-1:0]   id;
        logic [AXI_RESP_WD-1:0] resp;
    } b_t;

    typedef struct packed {
        logic [AXI_ID_WD-1:0]    id;
        logic [AXI_ADDR_WD-1:0]  addr;
        logic [AXI_LEN_WD-1:0]   len;
        logic [AXI_SIZE_WD-1:0]  size;
        logic [AXI_BURST_WD-1:0] burst;
    } ar_t;

    typedef struct packed {
        logic [AXI_ID_WD-1:0]   id;
        logic [AXI_DATA_WD-1:0] data;
        logic [AXI_RESP_WD-1:0] resp;
        logic                   last;
    } r_t;

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer: full throughput with a registered input ready.
// The output always drives the main register; skid only catches a beat during a stall.
module axi_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             ready_q;
    logic             in_hs, out_hs;

    assign in_hs     = in_valid && ready_q;
    assign out_hs    = main_valid_q && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

    // ready_q mirrors !skid_valid, so no input handshake happens while skid is full
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (out_hs) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            if (!main_valid_q || out_ready) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (out_hs) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one skid buffer per channel between master and axi_mem.
// Define AXI_REG_SLICE_LEN_CHECK_EN to enable the W burst-length checker.
module axi_reg_slice
    import axi_slice_pkg::*;
#(
`ifdef AXI_REG_SLICE_LEN_CHECK_EN
    parameter int unsigned LENQ_DEPTH = 4,
`endif
    parameter int unsigned ID_WD   = AXI_ID_WD,
    parameter int unsigned ADDR_WD = AXI_ADDR_WD,
    parameter int unsigned DATA_WD = AXI_DATA_WD,
    parameter int unsigned STRB_WD = DATA_WD / 8,
    parameter int unsigned LEN_WD  = AXI_LEN_WD,
    parameter int unsigned SIZE_WD = AXI_SIZE_WD
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [ID_WD-1:0]   S_AWID,
    input  logic [ADDR_WD-1:0] S_AWADDR,
    input  logic [LEN_WD-1:0]  S_AWLEN,
    input  logic [SIZE_WD-1:0] S_AWSIZE,
    input  logic [1:0]         S_AWBURST,
    input  logic               S_AWVALID,
    output logic               S_AWREADY,
    input  logic [DATA_WD-1:0] S_WDATA,
    input  logic [STRB_WD-1:0] S_WSTRB,
    input  logic               S_WLAST,
    input  logic               S_WVALID,
    output logic               S_WREADY,
    output logic [ID_WD-1:0]   S_BID,
    output logic [1:0]         S_BRESP,
    output logic               S_BVALID,
    input  logic               S_BREADY,
    input  logic [ID_WD-1:0]   S_ARID,
    input  logic [ADDR_WD-1:0] S_ARADDR,
    input  logic [LEN_WD-1:0]  S_ARLEN,
    input  logic [SIZE_WD-1:0] S_ARSIZE,
    input  logic [1:0]         S_ARBURST,
    input  logic               S_ARVALID,
    output logic               S_ARREADY,
    output logic [ID_WD-1:0]   S_RID,
    output logic [DATA_WD-1:0] S_RDATA,
    output logic [1:0]         S_RRESP,
    output logic               S_RLAST,
    output logic               S_RVALID,
    input  logic               S_RREADY,
    output logic [ID_WD-1:0]   M_AWID,
    output logic [ADDR_WD-1:0] M_AWADDR,
    output logic [LEN_WD-1:0]  M_AWLEN,
    output logic [SIZE_WD-1:0] M_AWSIZE,
    output logic [1:0]         M_AWBURST,
    output logic [3:0]         M_AWREGION,
    output logic [3:0]         M_AWCACHE,
    output logic [3:0]         M_AWQOS,
    output logic               M_AWLOCK,
    output logic [2:0]         M_AWPROT,
    output logic               M_AWVALID,
    input  logic               M_AWREADY,
    output logic [DATA_WD-1:0] M_WDATA,
    output logic [STRB_WD-1:0] M_WSTRB,
    output logic               M_WLAST,
    output logic               M_WVALID,
    input  logic               M_WREADY,
    input  logic [ID_WD-1:0]   M_BID,
    input  logic [1:0]         M_BRESP,
    input  logic               M_BVALID,
    output logic               M_BREADY,
    output logic [ID_WD-1:0]   M_ARID,
    output logic [ADDR_WD-1:0] M_ARADDR,
    output logic [LEN_WD-1:0]  M_ARLEN,
    output logic [SIZE_WD-1:0] M_ARSIZE,
    output logic [1:0]         M_ARBURST,
    output logic [3:0]         M_ARREGION,
    output logic [3:0]         M_ARCACHE,
    output logic [3:0]         M_ARQOS,
    output logic               M_ARLOCK,
    output logic [2:0]         M_ARPROT,
    output logic               M_ARVALID,
    input  logic               M_ARREADY,
    input  logic [ID_WD-1:0]   M_RID,
    input  logic [DATA_WD-1:0] M_RDATA,
    input  logic [1:0]         M_RRESP,
    input  logic               M_RLAST,
    input  logic               M_RVALID,
    output logic               M_RREADY,
    output logic               WLAST_ERR
);

    aw_t  aw_in, aw_out;
    w_t   w_in, w_out;
    b_t   b_in, b_out;
    ar_t  ar_in, ar_out;
    r_t   r_in, r_out;
    logic aw_out_valid, aw_out_ready;
    logic w_out_valid, w_out_ready;

    assign aw_in = {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST};
    assign w_in  = {S_WDATA, S_WSTRB, S_WLAST};
    assign b_in  = {M_BID, M_BRESP};
    assign ar_in = {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST};
    assign r_in  = {M_RID, M_RDATA, M_RRESP, M_RLAST};

    assign {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST} = aw_out;
    assign {M_WDATA, M_WSTRB, M_WLAST}                      = w_out;
    assign {S_BID, S_BRESP}                                 = b_out;
    assign {M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST} = ar_out;
    assign {S_RID, S_RDATA, S_RRESP, S_RLAST}               = r_out;

    assign M_AWREGION = 4'd0;
    assign M_AWCACHE  = 4'd0;
    assign M_AWQOS    = 4'd0;
    assign M_AWLOCK   = 1'b0;
    assign M_AWPROT   = 3'd0;
    assign M_ARREGION = 4'd0;
    assign M_ARCACHE  = 4'd0;
    assign M_ARQOS    = 4'd0;
    assign M_ARLOCK   = 1'b0;
    assign M_ARPROT   = 3'd0;

    axi_skid_buf #(.WIDTH($bits(aw_t))) u_aw_buf (
        .clk(ACLK), .rst(ARESET),
        .in_valid(S_AWVALID), .in_ready(S_AWREADY), .in_data(aw_in),
        .out_valid(aw_out_valid), .out_ready(aw_out_ready), .out_data(aw_out)
    );

    axi_skid_buf #(.WIDTH($bits(w_t))) u_w_buf (
        .clk(ACLK), .rst(ARESET),
        .in_valid(S_WVALID), .in_ready(S_WREADY), .in_data(w_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out)
    );

    axi_skid_buf #(.WIDTH($bits(b_t))) u_b_buf (
        .clk(ACLK), .rst(ARESET),
        .in_valid(M_BVALID), .in_ready(M_BREADY), .in_data(b_in),
        .out_valid(S_BVALID), .out_ready(S_BREADY), .out_data(b_out)
    );

    axi_skid_buf #(.WIDTH($bits(ar_t))) u_ar_buf (
        .clk(ACLK), .rst(ARESET),
        .in_valid(S_ARVALID), .in_ready(S_ARREADY), .in_data(ar_in),
        .out_valid(M_ARVALID), .out_ready(M_ARREADY), .out_data(ar_out)
    );

    axi_skid_buf #(.WIDTH($bits(r_t))) u_r_buf (
        .clk(ACLK), .rst(ARESET),
        .in_valid(M_RVALID), .in_ready(M_RREADY), .in_data(r_in),
        .out_valid(S_RVALID), .out_ready(S_RREADY), .out_data(r_out)
    );

`ifdef AXI_REG_SLICE_LEN_CHECK_EN
    localparam int unsigned PTR_WD = $clog2(LENQ_DEPTH);
    localparam logic [PTR_WD:0] PTR_ONE = 1;
    localparam logic [LEN_WD:0] CNT_ONE = 1;

    logic [LEN_WD-1:0] lenq_q [LENQ_DEPTH];
    logic [PTR_WD:0]   wr_ptr_q, rd_ptr_q;
    logic [LEN_WD:0]   beat_cnt_q;
    logic [LEN_WD-1:0] head_len;
    logic              lenq_full, lenq_empty, aw_block;
    logic              push, w_hs, pop, mismatch, err_q;

    assign lenq_empty = wr_ptr_q == rd_ptr_q;
    assign lenq_full  = (wr_ptr_q[PTR_WD] != rd_ptr_q[PTR_WD]) &&
                        (wr_ptr_q[PTR_WD-1:0] == rd_ptr_q[PTR_WD-1:0]);
    assign head_len   = lenq_q[rd_ptr_q[PTR_WD-1:0]];

    // A full queue still accepts an AW in the cycle a WLAST frees an entry
    assign w_hs         = M_WVALID && M_WREADY;
    assign pop          = w_hs && w_out.last;
    assign aw_block     = lenq_full && !pop;
    assign M_AWVALID    = aw_out_valid && !aw_block;
    assign aw_out_ready = M_AWREADY && !aw_block;
    assign push         = M_AWVALID && M_AWREADY;
    assign M_WVALID     = w_out_valid && !lenq_empty;
    assign w_out_ready  = M_WREADY && !lenq_empty;

    // beat_cnt counts beats already sent, so the last beat sees count == AWLEN
    assign mismatch = w_out.last ? (beat_cnt_q != {1'b0, head_len})
                                 : (beat_cnt_q == {1'b0, head_len});
    assign WLAST_ERR = err_q;

    always_ff @(posedge ACLK) begin
        if (push) begin
            lenq_q[wr_ptr_q[PTR_WD-1:0]] <= aw_out.len;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (w_hs) begin
                beat_cnt_q <= pop ? '0 : beat_cnt_q + CNT_ONE;
                if (mismatch) err_q <= 1'b1;
            end
        end
    end
`else
    assign M_AWVALID    = aw_out_valid;
    assign aw_out_ready = M_AWREADY;
    assign M_WVALID     = w_out_valid;
    assign w_out_ready  = M_WREADY;
    assign WLAST_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed bench for axi_reg_slice: latency, bursts, backpressure, reset and checker.
module tb_axi_reg_slice;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [2:0]  S_AWID, S_ARID, S_BID, S_RID, M_AWID, M_ARID, M_BID, M_RID;
    logic [31:0] S_AWADDR, S_ARADDR, M_AWADDR, M_ARADDR;
    logic [7:0]  S_AWLEN, S_ARLEN, M_AWLEN, M_ARLEN, S_WSTRB, M_WSTRB;
    logic [2:0]  S_AWSIZE, S_ARSIZE, M_AWSIZE, M_ARSIZE, M_AWPROT, M_ARPROT;
    logic [1:0]  S_AWBURST, S_ARBURST, M_AWBURST, M_ARBURST;
    logic [1:0]  S_BRESP, S_RRESP, M_BRESP, M_RRESP;
    logic [3:0]  M_AWREGION, M_AWCACHE, M_AWQOS, M_ARREGION, M_ARCACHE, M_ARQOS;
    logic        M_AWLOCK, M_ARLOCK;
    logic [63:0] S_WDATA, S_RDATA, M_WDATA, M_RDATA;
    logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic        S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
    logic        M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY;
    logic        WLAST_ERR;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    // W source on S side / sink on M side; R source on M side / sink on S side
    int w_n = 0, w_i = 0, w_o = 0;
    int r_n = 0, r_i = 0, r_o = 0;
    int r_first = 0, r_last = 0;
    logic [63:0] w_base = '0, r_base = '0;
    bit r_toggle = 1'b0, saw_stall = 1'b0;
    bit exp_err;

    always #5 ACLK = ~ACLK;

    axi_reg_slice dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
        .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWREGION(M_AWREGION), .M_AWCACHE(M_AWCACHE),
        .M_AWQOS(M_AWQOS), .M_AWLOCK(M_AWLOCK), .M_AWPROT(M_AWPROT),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARREGION(M_ARREGION), .M_ARCACHE(M_ARCACHE),
        .M_ARQOS(M_ARQOS), .M_ARLOCK(M_ARLOCK), .M_ARPROT(M_ARPROT),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .WLAST_ERR(WLAST_ERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        S_WVALID = (w_i < w_n);
        S_WDATA  = w_base + 64'(w_i);
        S_WLAST  = (w_i == w_n - 1);
        M_RVALID = (r_i < r_n);
        M_RDATA  = r_base + 64'(r_i);
        M_RLAST  = (r_i == r_n - 1);
    endtask

    // Handshakes are judged at the negedge, inputs change 1 time unit after posedge
    task automatic tick();
        bit w_in, r_in;
        @(negedge ACLK);
        w_in = S_WVALID && S_WREADY;
        r_in = M_RVALID && M_RREADY;
        if (r_toggle && !M_RREADY) saw_stall = 1'b1;
        if (M_WVALID && M_WREADY) begin
            chk("w_data", M_WDATA, w_base + 64'(w_o));
            chk("w_last", 64'(M_WLAST), 64'(w_o == w_n - 1));
            w_o++;
        end
        if (S_RVALID && S_RREADY) begin
            chk("r_data", S_RDATA, r_base + 64'(r_o));
            chk("r_last", 64'(S_RLAST), 64'(r_o == r_n - 1));
            if (r_o == 0) r_first = cyc;
            r_last = cyc;
            r_o++;
        end
        @(posedge ACLK);
        cyc++;
        #1;
        if (w_in) w_i++;
        if (r_in) r_i++;
        drive();
        if (r_toggle) S_RREADY = !S_RREADY;
    endtask

    initial begin
`ifdef AXI_REG_SLICE_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        ARESET = 1'b1;
        {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID} = '0;
        {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID} = '0;
        S_WSTRB = 8'hFF;
        {S_BREADY, S_RREADY, M_AWREADY, M_WREADY, M_ARREADY} = '0;
        {M_BID, M_BRESP, M_BVALID, M_RID, M_RRESP} = '0;
        drive();

        // Reset state
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, S_BVALID, S_RVALID}), 64'd0);
        chk("rst_readies", 64'({S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY}), 64'd0);
        chk("rst_err", 64'(WLAST_ERR), 64'd0);
        chk("rst_payload", M_AWADDR, 64'd0);
        #2 ARESET = 1'b0;
        #1 chk("ready_before_edge", 64'(S_AWREADY), 64'd0);
        @(posedge ACLK);
        #1;
        chk("ready_after_edge", 64'({S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY}),
            64'h1F);

        // Single-beat write
        {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST} = {3'd2, 32'h100, 8'd0, 3'd3, 2'd1};
        S_AWVALID = 1'b1;
        chk("aw_pre", 64'(M_AWVALID), 64'd0);
        tick();
        S_AWVALID = 1'b0;
        chk("aw_lat", 64'(M_AWVALID), 64'd1);
        chk("aw_addr", 64'(M_AWADDR), 64'h100);
        chk("aw_id_len", 64'({M_AWID, M_AWLEN}), 64'({3'd2, 8'd0}));
        chk("aw_tie", 64'({M_AWREGION, M_AWCACHE, M_AWQOS, M_AWLOCK, M_AWPROT}), 64'd0);
        M_AWREADY = 1'b1;
        tick();
        chk("aw_drain", 64'(M_AWVALID), 64'd0);
        w_base = 64'hDEADBEEF_CAFEF00D;
        w_n = 1; w_i = 0; w_o = 0;
        M_WREADY = 1'b1;
        drive();
        repeat (3) tick();
        chk("w_single_cnt", 64'(w_o), 64'd1);
        S_BREADY = 1'b1;
        {M_BID, M_BRESP, M_BVALID} = {3'd2, 2'b00, 1'b1};
        tick();
        M_BVALID = 1'b0;
        chk("b_lat", 64'(S_BVALID), 64'd1);
        chk("b_resp_id", 64'({S_BID, S_BRESP}), 64'({3'd2, 2'b00}));
        tick();
        chk("b_drain", 64'(S_BVALID), 64'd0);

        // Burst read, ARLEN=7
        {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST} = {3'd5, 32'h200, 8'd7, 3'd3, 2'd1};
        S_ARVALID = 1'b1;
        tick();
        S_ARVALID = 1'b0;
        chk("ar_fwd", 64'({M_ARVALID, M_ARID, M_ARLEN}), 64'({1'b1, 3'd5, 8'd7}));
        chk("ar_addr", 64'(M_ARADDR), 64'h200);
        M_ARREADY = 1'b1;
        M_RID = 3'd5;
        tick();
        chk("ar_drain", 64'(M_ARVALID), 64'd0);
        S_RREADY = 1'b1;
        r_base = 64'h0000_0200_0000_0000;
        r_n = 8; r_i = 0; r_o = 0;
        drive();
        for (int k = 0; k < 40 && r_o < 8; k++) tick();
        chk("r_burst_cnt", 64'(r_o), 64'd8);
        chk("r_no_bubble", 64'(r_last - r_first), 64'd7);
        chk("r_id", 64'(S_RID), 64'd5);

        // W backpressure: 16 beats, downstream stalls for 5 cycles
        S_AWLEN = 8'd15;
        S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        tick();
        w_base = 64'h1111_2222_0000_0000;
        w_n = 16; w_i = 0; w_o = 0;
        drive();
        repeat (4) tick();
        M_WREADY = 1'b0;
        repeat (5) tick();
        chk("bp_ready_low", 64'(S_WREADY), 64'd0);
        chk("bp_absorbed", 64'(w_i - w_o), 64'd2);
        chk("bp_hold", M_WDATA, w_base + 64'(w_o));
        M_WREADY = 1'b1;
        for (int k = 0; k < 60 && w_o < 16; k++) tick();
        chk("bp_total", 64'({w_i, w_o}), 64'({32'd16, 32'd16}));
        chk("bp_no_err", 64'(WLAST_ERR), 64'd0);

        // R stream with sink ready toggling every cycle
        r_base = 64'hABCD_0000_0000_1000;
        r_n = 100; r_i = 0; r_o = 0;
        r_toggle = 1'b1;
        drive();
        for (int k = 0; k < 600 && r_o < 100; k++) tick();
        r_toggle = 1'b0;
        S_RREADY = 1'b1;
        chk("tog_cnt", 64'(r_o), 64'd100);
        chk("tog_stalled", 64'(saw_stall), 64'd1);
        repeat (2) tick();
        chk("tog_no_extra", 64'(r_o), 64'd100);

        // Reset asserted during beat 3 of an ARLEN=7 read
        S_ARVALID = 1'b1;
        tick();
        S_ARVALID = 1'b0;
        r_base = 64'h5555_0000_0000_0000;
        r_n = 8; r_i = 0; r_o = 0;
        drive();
        for (int k = 0; k < 40 && r_o < 2; k++) tick();
        chk("mid_beats", 64'(r_o), 64'd2);
        #2 ARESET = 1'b1;
        #1;
        chk("mid_valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, S_BVALID, S_RVALID}), 64'd0);
        chk("mid_readies", 64'({S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY}), 64'd0);
        r_n = 0; r_i = 0; r_o = 0;
        drive();
        #2 ARESET = 1'b0;
        #1 chk("mid_ready_held", 64'(S_ARREADY), 64'd0);
        @(posedge ACLK);
        #1;
        chk("mid_ready_rise", 64'({S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY}),
            64'h1F);
        repeat (3) tick();
        chk("mid_no_replay", 64'({S_RVALID, M_ARVALID}), 64'd0);

        // AWLEN=3 with WLAST on the third beat
        {S_AWID, S_AWLEN} = {3'd1, 8'd3};
        S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        tick();
        w_base = 64'h7777_0000_0000_0000;
        w_n = 3; w_i = 0; w_o = 0;
        drive();
        repeat (6) tick();
        chk("chk_beats", 64'(w_o), 64'd3);
        chk("chk_err", 64'(WLAST_ERR), 64'(exp_err));
        repeat (3) tick();
        chk("chk_err_sticky", 64'(WLAST_ERR), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_reg_slice.md
# axi_reg_slice

Full-throughput AXI4 register slice placed directly upstream of the `axi_mem` slave model. It breaks every combinational path between the test master and the memory model on all five channels (AW, W, B, AR, R) without losing bandwidth. Each channel uses a two-entry skid buffer. An optional checker verifies that W burst lengths match the AWLEN values that were forwarded.

## Interface
- `ID_WD`, 3, ID width on AW/B/AR/R
- `ADDR_WD`, 32, address width
- `DATA_WD`, 64, data width
- `STRB_WD`, `DATA_WD/8`, write-strobe width
- `LEN_WD`, 8, burst-length width
- `SIZE_WD`, 3, burst-size width
- `LENQ_DEPTH`, 4, depth of the AWLEN queue (checker only, power of two)
- `ACLK`  in  1  sole clock, rising edge
- `ARESET`  in  1  asynchronous, active-high reset
- `S_AW{ID,ADDR,LEN,SIZE,BURST,VALID}` in / `S_AWREADY` out: AW payload from the master
- `S_W{DATA,STRB,LAST,VALID}` in / `S_WREADY` out: W payload from the master
- `S_B{ID,RESP,VALID}` out / `S_BREADY` in: B response to the master
- `S_AR{ID,ADDR,LEN,SIZE,BURST,VALID}` in / `S_ARREADY` out: AR payload from the master
- `S_R{ID,DATA,RESP,LAST,VALID}` out / `S_RREADY` in: R data to the master
- `M_*` mirror of all the above toward `axi_mem`, with directions reversed
- `M_AW/AR{REGION,CACHE,QOS}` out 4, `M_AW/AR{LOCK}` out 1, `M_AW/AR{PROT}` out 3: tied to 0
- `WLAST_ERR`  out  1  sticky burst-length mismatch flag (checker only)

## Operation
- Each channel has one skid buffer with a main register and a skid register.
  - Input ready = !skid_valid, registered.
  - Output drives main.
- Transfer rules:
  - Input handshake while main is empty or draining: the beat loads main.
  - Input handshake while main is held (valid && !ready): the beat loads skid, and ready drops next cycle.
  - Output handshake while skid is full: skid moves to main, and ready rises next cycle.
- Payload is forwarded bit-exact and in order. There is no reordering across channels or IDs.
- Forward and backward channels are independent; AW and W are not coupled (except in checker mode).
- Channels do not interact. Simultaneous input and output handshakes on one buffer are lossless.

## Timing
- Latency: one cycle from input handshake to output valid when the buffer is empty.
- Sustained throughput: 1 beat/cycle per channel while the downstream ready stays high.
- Backpressure: after downstream ready drops, at most 2 beats are absorbed before input ready deasserts. Input ready is a registered signal and never combinational from output ready.
- Output valid stays asserted with stable payload until the handshake completes.
- Reset values:
  - All valids are 0, all readies are 0, and `WLAST_ERR` is 0.
  - Payload registers reset to 0.
  - Readies rise on the first `ACLK` edge after `ARESET` falls.
- Reset asserted mid-burst: all in-flight beats are dropped immediately (asynchronous), and nothing is replayed.

## Configuration
- Macro `AXI_REG_SLICE_LEN_CHECK_EN`.
- Defined:
  - The AWLEN queue (`LENQ_DEPTH` entries) pushes on each M_AW handshake.
  - A beat counter (`LEN_WD+1` bits) increments on each M_W handshake.
  - At an M_W handshake with WLAST=1 while count != head AWLEN, or with WLAST=0 while count == head AWLEN, `WLAST_ERR` is set. It is sticky until `ARESET`.
  - On a WLAST beat the queue pops and the count clears.
  - `M_AWVALID` is masked while the queue is full. `M_WVALID` is masked while the queue is empty.
  - Push and pop in the same cycle on a full queue are both allowed.
- Undefined: no queue, no masking, and `WLAST_ERR` is tied to 0.

## Structure
- The shared package `axi_slice_pkg` holds:
  - the `aw_t`, `w_t`, `b_t`, `ar_t`, `r_t` packed payload typedefs, parameterised by the widths above;
  - the `AXI_RESP_OKAY` constant.
- Sub-module `axi_skid_buf`, with a generic width parameter, is instantiated five times.
- The top level holds the channel concatenation and the optional checker.

## Test plan
- Single-beat write: AWADDR=0x100, AWLEN=0, WDATA=0xDEADBEEF_CAFEF00D, BREADY=1 -> M_AW appears 1 cycle later; BRESP=0 returns to S_B 1 cycle after M_B.
- Burst read: ARLEN=7, M_RREADY=1, S_RREADY held 1 -> 8 R beats, back-to-back with no bubble, RLAST on beat 8, data equal to memory contents.
- Backpressure: stream 16 W beats and drop M_WREADY for 5 cycles -> S_WREADY falls after 2 beats absorbed; no beat is lost or duplicated, and order is preserved.
- Simultaneous load and drain with the skid register full, toggling ready every cycle for 100 beats -> exact beat count and ordering, verified by scoreboard.
- Reset mid-burst: ARESET high during beat 3 of an ARLEN=7 read -> all valids are 0 in the same cycle; readies are 1 on the first edge after release.
- Checker (`_EN` defined): AWLEN=3 followed by 3 W beats with WLAST on the 3rd -> `WLAST_ERR`=1 and stays set; with the macro undefined, the same stimulus gives `WLAST_ERR`=0.
